alu_8bit: RTL and testbench



---
 rtl/alu_8bit_pkg.sv | 19 +
 rtl/alu_8bit_core.sv | 66 ++++++
 rtl/alu_8bit.sv | 86 ++++++++
 tb/tb_alu_8bit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/alu_8bit_pkg.sv
// alu_8bit_pkg: shared constants for the 8-bit execute-stage ALU.
//   DATA_W   - datapath width (fixed at 8)
//   opcode_e - 3-bit operation select encodings (OP_ADD .. OP_SHLB)
package alu_8bit_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_CMP  = 3'b101,
    OP_SHLA = 3'b110,
    OP_SHLB = 3'b111
  } opcode_e;

endpackage

// File: rtl/alu_8bit_core.sv
// alu_8bit_core: purely combinational ALU datapath.
//   a, b    in  operands (unsigned)
//   opcode  in  operation select (see alu_8bit_pkg::opcode_e)
//   result  out 8-bit result
//   c_flag  out compare flag (CMP: A > B)
//   c_out   out carry (ADD), borrow (SUB), shifted-out bit (SHLA/SHLB)
//   zero    out result == 0; present only when ALU_ZERO_FLAG_EN is defined
module alu_8bit_core
  import alu_8bit_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              c_flag,
  output logic              c_out
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic              zero
`endif
);

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Zero-extended to 9 bits: bit 8 of the sum is the carry, bit 8 of the
  // difference is set exactly when a < b (borrow).
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  always_comb begin
    result = '0;
    c_flag = 1'b0;
    c_out  = 1'b0;
    case (opcode_e'(opcode))
      OP_ADD: begin
        result = sum[DATA_W-1:0];
        c_out  = sum[DATA_W];
      end
      OP_SUB: begin
        result = diff[DATA_W-1:0];
        c_out  = diff[DATA_W];
      end
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_CMP: begin
        c_flag = (a > b);
        result = {{(DATA_W-1){1'b0}}, c_flag};
      end
      OP_SHLA: begin
        result = {a[DATA_W-2:0], 1'b0};
        c_out  = a[DATA_W-1];
      end
      OP_SHLB: begin
        result = {b[DATA_W-2:0], 1'b0};
        c_out  = b[DATA_W-1];
      end
    endcase
  end

`ifdef ALU_ZERO_FLAG_EN
  assign zero = (result == '0);
`endif

endmodule

// File: rtl/alu_8bit.sv
// alu_8bit: registered 8-bit ALU (execute stage), one operation per cycle,
// one cycle latency, no handshake.
//   clk         in  clock, rising edge
//   rst         in  synchronous active-high reset (priority over operation)
//   A, B        in  8-bit unsigned operands
//   opcode      in  3-bit operation select
//   ALU_output  out registered result
//   C_flag      out registered compare flag
//   C_out       out registered carry/borrow/shift-out
//   Z_flag      out registered zero flag (only with `define ALU_ZERO_FLAG_EN)
module alu_8bit
  import alu_8bit_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] A,
  input  logic [DATA_W-1:0] B,
  input  logic [2:0]        opcode,
  output logic [DATA_W-1:0] ALU_output,
  output logic              C_flag,
  output logic              C_out
`ifdef ALU_ZERO_FLAG_EN
  ,
  output logic              Z_flag
`endif
);

  logic [DATA_W-1:0] alu_output_d, alu_output_q;
  logic              c_flag_d, c_flag_q;
  logic              c_out_d, c_out_q;
  logic [DATA_W-1:0] core_result;
  logic              core_c_flag;
  logic              core_c_out;
`ifdef ALU_ZERO_FLAG_EN
  logic              core_zero;
  logic              z_flag_d, z_flag_q;
`endif

  alu_8bit_core u_core (
    .a      (A),
    .b      (B),
    .opcode (opcode),
    .result (core_result),
    .c_flag (core_c_flag),
    .c_out  (core_c_out)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .zero   (core_zero)
`endif
  );

  always_comb begin
    alu_output_d = core_result;
    c_flag_d     = core_c_flag;
    c_out_d      = core_c_out;
`ifdef ALU_ZERO_FLAG_EN
    z_flag_d     = core_zero;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_output_q <= '0;
      c_flag_q     <= 1'b0;
      c_out_q      <= 1'b0;
`ifdef ALU_ZERO_FLAG_EN
      z_flag_q     <= 1'b1; // consistent with the zero result held in reset
`endif
    end else begin
      alu_output_q <= alu_output_d;
      c_flag_q     <= c_flag_d;
      c_out_q      <= c_out_d;
`ifdef ALU_ZERO_FLAG_EN
      z_flag_q     <= z_flag_d;
`endif
    end
  end

  assign ALU_output = alu_output_q;
  assign C_flag     = c_flag_q;
  assign C_out      = c_out_q;
`ifdef ALU_ZERO_FLAG_EN
  assign Z_flag     = z_flag_q;
`endif

endmodule

// File: tb/tb_alu_8bit.sv
// tb_alu_8bit: directed self-checking bench for alu_8bit.
// Each vector is applied before a rising edge and the registered outputs
// are sampled 1 time unit after that edge.
module tb_alu_8bit;
  import alu_8bit_pkg::*;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] op;
    logic [7:0] res;
    logic       cf;
    logic       co;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] A = '0;
  logic [7:0] B = '0;
  logic [2:0] opcode = '0;
  logic [7:0] ALU_output;
  logic       C_flag;
  logic       C_out;
`ifdef ALU_ZERO_FLAG_EN
  logic       Z_flag;
`endif

  int checks   = 0;
  int failures = 0;

  alu_8bit dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .B          (B),
    .opcode     (opcode),
    .ALU_output (ALU_output),
    .C_flag     (C_flag),
    .C_out      (C_out)
`ifdef ALU_ZERO_FLAG_EN
    ,
    .Z_flag     (Z_flag)
`endif
  );

  always #5 clk = ~clk;

  // Drive one operation and advance to just after the sampling edge.
  task automatic step(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    A = a;
    B = b;
    opcode = op;
    @(posedge clk);
    #1;
  endtask

  // Apply a table of vectors, one per cycle, comparing each result.
  task automatic run_table(input string name, input vec_t v[]);
    foreach (v[i]) begin
      step(v[i].a, v[i].b, v[i].op);
      checks++;
      if ({ALU_output, C_flag, C_out} !== {v[i].res, v[i].cf, v[i].co}) begin
        failures++;
        $display("FAIL %s[%0d] op=%0d a=%0d b=%0d got res=%0d cf=%b co=%b exp res=%0d cf=%b co=%b",
                 name, i, v[i].op, v[i].a, v[i].b, ALU_output, C_flag, C_out,
                 v[i].res, v[i].cf, v[i].co);
      end
`ifdef ALU_ZERO_FLAG_EN
      checks++;
      if (Z_flag !== (v[i].res == 8'h00)) begin
        failures++;
        $display("FAIL %s_z[%0d] got=%b exp=%b", name, i, Z_flag, (v[i].res == 8'h00));
      end
`endif
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(8'd50, 8'd40, OP_ADD);
      checks++;
      if ({ALU_output, C_flag, C_out} !== {8'h00, 1'b0, 1'b0}) begin
        failures++;
        $display("FAIL reset_cycle%0d got res=%0d cf=%b co=%b exp res=0 cf=0 co=0",
                 i, ALU_output, C_flag, C_out);
      end
`ifdef ALU_ZERO_FLAG_EN
      checks++;
      if (Z_flag !== 1'b1) begin
        failures++;
        $display("FAIL reset_z%0d got=%b exp=1", i, Z_flag);
      end
`endif
    end
    rst = 1'b0;
    step(8'd50, 8'd40, OP_ADD);
    checks++;
    if ({ALU_output, C_flag, C_out} !== {8'd90, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_release got res=%0d cf=%b co=%b exp res=90 cf=0 co=0",
               ALU_output, C_flag, C_out);
    end
  endtask

  task automatic test_add();
    vec_t v[] = '{
      '{a: 8'd50,  b: 8'd40,  op: OP_ADD, res: 8'd90, cf: 1'b0, co: 1'b0},
      '{a: 8'd200, b: 8'd100, op: OP_ADD, res: 8'd44, cf: 1'b0, co: 1'b1}
    };
    run_table("add", v);
  endtask

  task automatic test_sub();
    vec_t v[] = '{
      '{a: 8'd50, b: 8'd40, op: OP_SUB, res: 8'd10,  cf: 1'b0, co: 1'b0},
      '{a: 8'd40, b: 8'd50, op: OP_SUB, res: 8'd246, cf: 1'b0, co: 1'b1}
    };
    run_table("sub", v);
  endtask

  task automatic test_logic();
    vec_t v[] = '{
      '{a: 8'h17, b: 8'h1E, op: OP_AND, res: 8'h16, cf: 1'b0, co: 1'b0},
      '{a: 8'h41, b: 8'h02, op: OP_OR,  res: 8'h43, cf: 1'b0, co: 1'b0},
      '{a: 8'h21, b: 8'h53, op: OP_XOR, res: 8'h72, cf: 1'b0, co: 1'b0}
    };
    run_table("logic", v);
  endtask

  task automatic test_cmp();
    vec_t v[] = '{
      '{a: 8'd10, b: 8'd5,  op: OP_CMP, res: 8'd1, cf: 1'b1, co: 1'b0},
      '{a: 8'd5,  b: 8'd10, op: OP_CMP, res: 8'd0, cf: 1'b0, co: 1'b0},
      '{a: 8'd7,  b: 8'd7,  op: OP_CMP, res: 8'd0, cf: 1'b0, co: 1'b0}
    };
    run_table("cmp", v);
  endtask

  task automatic test_shift();
    vec_t v[] = '{
      '{a: 8'h0A, b: 8'h00, op: OP_SHLA, res: 8'h14, cf: 1'b0, co: 1'b0},
      '{a: 8'h00, b: 8'h05, op: OP_SHLB, res: 8'h0A, cf: 1'b0, co: 1'b0},
      '{a: 8'h81, b: 8'h00, op: OP_SHLA, res: 8'h02, cf: 1'b0, co: 1'b1}
    };
    run_table("shift", v);
  endtask

  task automatic test_back_to_back();
    vec_t v[] = '{
      '{a: 8'hFF, b: 8'h01, op: OP_ADD,  res: 8'h00, cf: 1'b0, co: 1'b1},
      '{a: 8'h00, b: 8'h01, op: OP_SUB,  res: 8'hFF, cf: 1'b0, co: 1'b1},
      '{a: 8'hFF, b: 8'hFE, op: OP_CMP,  res: 8'h01, cf: 1'b1, co: 1'b0},
      '{a: 8'h00, b: 8'h80, op: OP_SHLB, res: 8'h00, cf: 1'b0, co: 1'b1},
      '{a: 8'hFF, b: 8'h0F, op: OP_XOR,  res: 8'hF0, cf: 1'b0, co: 1'b0},
      '{a: 8'hAA, b: 8'h55, op: OP_AND,  res: 8'h00, cf: 1'b0, co: 1'b0},
      '{a: 8'h80, b: 8'h01, op: OP_OR,   res: 8'h81, cf: 1'b0, co: 1'b0},
      '{a: 8'hFF, b: 8'h00, op: OP_SHLA, res: 8'hFE, cf: 1'b0, co: 1'b1},
      '{a: 8'h00, b: 8'hFF, op: OP_CMP,  res: 8'h00, cf: 1'b0, co: 1'b0}
    };
    run_table("b2b", v);
  endtask

  task automatic test_reset_midstream();
    step(8'd200, 8'd100, OP_ADD);
    rst = 1'b1;
    step(8'd10, 8'd5, OP_CMP);
    checks++;
    if ({ALU_output, C_flag, C_out} !== {8'h00, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_mid got res=%0d cf=%b co=%b exp res=0 cf=0 co=0",
               ALU_output, C_flag, C_out);
    end
    rst = 1'b0;
    step(8'd40, 8'd50, OP_SUB);
    checks++;
    if ({ALU_output, C_flag, C_out} !== {8'd246, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL reset_mid_resume got res=%0d cf=%b co=%b exp res=246 cf=0 co=1",
               ALU_output, C_flag, C_out);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_sub();
    test_logic();
    test_cmp();
    test_shift();
    test_back_to_back();
    test_reset_midstream();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
